// File: rtl/bcd_alu_pkg.sv
// Shared types and constants for the digit-serial BCD ALU: FSM state encoding,
// opcode values and the default operand width in digits.
package bcd_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic       OP_ADD         = 1'b0;
  localparam logic       OP_SUB         = 1'b1;
  localparam logic [3:0] BCD_MAX        = 4'd9;
  localparam int         DEFAULT_DIGITS = 3;

endpackage

// File: rtl/bcd_digit_unit.sv
// Combinational single-digit BCD add/subtract cell with carry/borrow chain.
// The chain bit is a carry in add mode and a borrow in subtract mode.
module bcd_digit_unit
  import bcd_alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       chain_in,
  input  logic       op,
  output logic [3:0] digit,
  output logic       chain_out
);

  logic [4:0] sum;
  logic [4:0] diff;
  logic [4:0] adj;

  assign sum  = {1'b0, a} + {1'b0, b} + {4'd0, chain_in};
  // diff[4] set means the 5-bit difference wrapped below zero.
  assign diff = {1'b0, a} - {1'b0, b} - {4'd0, chain_in};

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    digit     = 4'd0;
    chain_out = 1'b0;
    adj       = 5'd0;
    if (op == OP_ADD) begin
      if (sum > {1'b0, BCD_MAX}) begin
        adj       = sum - 5'd10;
        chain_out = 1'b1;
      end else begin
        adj = sum;
      end
    end else begin
      if (diff[4]) begin
        adj       = diff + 5'd10;
        chain_out = 1'b1;
      end else begin
        adj = diff;
      end
    end
    digit = adj[3:0];
  end

endmodule

// File: rtl/bcd_serial_alu_ctrl.sv
// Digit-serial BCD add/subtract sequencer: drives one shared digit cell LSD-first,
// and on a subtract borrow runs a second pass to produce sign-magnitude output.
module bcd_serial_alu_ctrl
  import bcd_alu_pkg::*;
#(
  parameter int DIGITS = DEFAULT_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  carry_out,
  output logic                  negative,
  output logic                  err
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t              state, next_state;
  logic [4*DIGITS-1:0] a_q, b_q;
  logic                op_q;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W+1:0]    bit_pos;
  logic                chain;
  logic                last_digit;
  logic                invalid;

  logic [3:0]          unit_a, unit_b, unit_digit;
  logic                unit_op, unit_chain_out;

  assign bit_pos    = {idx, 2'b00};
  assign last_digit = (idx == LAST_IDX);

  always_comb begin
    invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[i*4 +: 4] > BCD_MAX || b[i*4 +: 4] > BCD_MAX) invalid = 1'b1;
    end
  end

  bcd_digit_unit u_digit (
    .a         (unit_a),
    .b         (unit_b),
    .chain_in  (chain),
    .op        (unit_op),
    .digit     (unit_digit),
    .chain_out (unit_chain_out)
  );

  // FIX re-uses the cell as 0 - raw digit - borrow to form the ten's complement.
  always_comb begin
    next_state = state;
    unit_a     = a_q[bit_pos +: 4];
    unit_b     = b_q[bit_pos +: 4];
    unit_op    = op_q;
    case (state)
      IDLE: if (start) next_state = invalid ? DONE : RUN;
      RUN: begin
        if (last_digit) next_state = (op_q == OP_SUB && unit_chain_out) ? FIX : DONE;
      end
      FIX: begin
        unit_a  = 4'd0;
        unit_b  = result[bit_pos +: 4];
        unit_op = OP_SUB;
        if (last_digit) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_ADD;
      idx       <= '0;
      chain     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      negative  <= 1'b0;
      err       <= 1'b0;
    end else begin
      busy <= (next_state != IDLE);
      done <= (next_state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_q       <= a;
            b_q       <= b;
            op_q      <= op;
            idx       <= '0;
            chain     <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            negative  <= 1'b0;
            err       <= invalid;
          end
        end
        RUN: begin
          result[bit_pos +: 4] <= unit_digit;
          if (last_digit) begin
            idx   <= '0;
            chain <= 1'b0;
            if (op_q == OP_ADD) carry_out <= unit_chain_out;
            else if (unit_chain_out) negative <= 1'b1;
          end else begin
            idx   <= idx + IDX_W'(1);
            chain <= unit_chain_out;
          end
        end
        FIX: begin
          result[bit_pos +: 4] <= unit_digit;
          if (last_digit) begin
            idx   <= '0;
            chain <= 1'b0;
          end else begin
            idx   <= idx + IDX_W'(1);
            chain <= unit_chain_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bcd_serial_alu_ctrl.md
# bcd_serial_alu_ctrl

Digit-serial sequencer for the 3-digit BCD ALU. It accepts two packed BCD operands and an add/subtract opcode, then drives one shared single-digit BCD add/subtract unit LSD-first, one digit per clock, while it carries the carry/borrow between digits. When a subtraction ends with a borrow, it runs a second pass that converts the result to sign-magnitude. It replaces a DIGITS-wide ripple of digit cells with one cell plus this controller.

## Interface
- DIGITS, 3, number of BCD digits per operand (≥1)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only in IDLE
- op  in  1  0 = add, 1 = subtract (a − b)
- a  in  4*DIGITS  operand A, packed BCD, digit 0 in [3:0]
- b  in  4*DIGITS  operand B, packed BCD
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- result  out  4*DIGITS  BCD sum or magnitude of the difference
- carry_out  out  1  add overflow (sum ≥ 10^DIGITS)
- negative  out  1  subtract result < 0; result holds |a − b|
- err  out  1  an operand digit > 9 at start

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE: when start=1, latch a, b and op. Clear the digit index, carry/borrow, carry_out, negative and err.
  - If any latched digit is > 9: result ← 0, err ← 1, go to DONE.
  - Otherwise go to RUN.
- RUN: each cycle, feed digit[idx] of A and B plus the chain bit to the digit unit, write its output to result digit[idx] and update the chain bit.
  - Add: s = a+b+cin; if s > 9 then digit = s−10 and cout = 1.
  - Sub: d = a−b−bin; if d < 0 then digit = d+10 and bout = 1.
  - After digit DIGITS−1:
    - add: carry_out ← final carry, go to DONE.
    - sub with no final borrow: go to DONE.
    - sub with final borrow: negative ← 1, clear idx and borrow, go to FIX.
- FIX: compute digit[idx] ← 0 − result[idx] − borrow in sub mode, one digit per cycle. This yields 10^DIGITS − raw = |a − b|. After the last digit, go to DONE.
- DONE: done = 1 for one cycle, then go to IDLE.
- start is ignored while busy. Latched operands are unaffected by input changes during an operation.
- result, carry_out, negative and err hold their values after done until the next accepted start.
- Subtracting equal operands gives result 0, negative 0. A zero result is never negative.

## Timing
- Reset (async assert, any state): state = IDLE, busy = 0, done = 0, result = 0, carry_out = 0, negative = 0, err = 0, idx = 0, chain bit = 0. An operation in flight is abandoned and no done is produced.
- Let T be the clock edge that samples start in IDLE. Edge T+k is the k-th edge after T; "done high after edge X" means done is high for the one cycle between edge X and the next edge.
  - Add, or subtract without a final borrow: done high after edge T+DIGITS. Latency is DIGITS+1 cycles.
  - Subtract with a final borrow: done high after edge T+2·DIGITS.
  - Invalid digit: done high after edge T.
- busy is high from edge T through the DONE cycle inclusive. It is low in the cycle after DONE, and a new start can be accepted at that cycle's closing edge.
- All outputs are registered. result bits are final no later than the cycle in which done is high.

## Structure
- Package bcd_alu_pkg holds:
  - the state enum {IDLE, RUN, FIX, DONE}
  - OP_ADD = 1'b0, OP_SUB = 1'b1
  - BCD_MAX = 4'd9
  - the default DIGITS
- Sub-module bcd_digit_unit: combinational one-digit add/subtract.
  - Inputs: a[3:0], b[3:0], chain_in, op.
  - Outputs: digit[3:0], chain_out.
  - It uses 5-bit intermediates.
- In FIX, the controller drives the digit unit with a = 0, b = result digit, op = OP_SUB.

## Test plan
- 123 + 456, op = 0 → result 579, carry_out 0, done high after edge T+3, busy high for 4 cycles.
- 999 + 001 → result 000, carry_out 1, negative 0.
- 456 − 123 → 333, negative 0, done high after edge T+3. Also 500 − 500 → 000, negative 0.
- 123 − 456 → raw 667 after RUN, then result 333, negative 1, done high after edge T+6. Also 000 − 001 → 001, negative 1.
- a = 12A (hex nibble A), b = 000 → err 1, result 000, done high after edge T.
- While busy: a second start with new operands is ignored. Then rst_n pulses low mid-RUN → all outputs 0 immediately and no done. A fresh 250 + 250 after release → 500.
